// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register controller: FSM states, command fields, defaults.
// Pure declarations; no logic, no latency, no flow control.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_DROP
    } state_e;

    localparam int         CMD_W_BIT    = 7;
    localparam logic [7:0] ID_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] RSV_MASK_DEF = 8'h78;

    // Bits between the W flag and the address field must be zero in a legal command.
    function automatic logic [7:0] rsv_mask(input int addr_w);
        return 8'h7F & ~((8'd1 << addr_w) - 8'd1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2-3 cycle latency, no flow control.
// Reset value is a parameter so an inactive-high input such as a chip select stays idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder with burst register write/read; writes and tx loads land 1 cycle after i_rx_valid.
// No backpressure: every i_rx_valid pulse is consumed in the cycle it arrives.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter int         ADDR_W   = 3,
    parameter logic [7:0] ID_BYTE  = ID_BYTE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_cs,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_load,
    output logic [8*NUM_REGS-1:0] o_regs,
    output logic                  o_wr_strobe,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [7:0]            o_err_cnt
);

    localparam logic [7:0] RSV_MASK = rsv_mask(ADDR_W);

    logic cs_s;
    logic cs_q;
    logic cs_rise;
    logic cs_fall;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
    logic              init_q;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_sys_rst),
        .i_d     (i_cs),
        .o_q     (cs_s)
    );

    assign cs_rise  = cs_s & ~cs_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign addr_inc = addr_q + ADDR_W'(1);
    assign cmd_addr = i_rx_byte[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        tx_byte_d   = tx_byte_q;
        tx_load_d   = init_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (i_rx_valid) begin
                    if ((i_rx_byte & RSV_MASK) != 8'h00) begin
                        state_d = ST_DROP;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end else if (i_rx_byte[CMD_W_BIT]) begin
                        state_d = ST_WR;
                        addr_d  = cmd_addr;
                    end else begin
                        state_d   = ST_RD;
                        addr_d    = cmd_addr;
                        tx_byte_d = regs_q[cmd_addr];
                        tx_load_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (i_rx_valid) begin
                    regs_d[addr_q] = i_rx_byte;
                    wr_strobe_d    = 1'b1;
                    wr_addr_d      = addr_q;
                    addr_d         = addr_inc;
                end
            end
            ST_RD: begin
                if (i_rx_valid) begin
                    addr_d    = addr_inc;
                    tx_byte_d = regs_q[addr_inc];
                    tx_load_d = 1'b1;
                end
            end
            default: ;
        endcase

        // End of frame wins over any read load but lets the same-cycle write commit.
        if (cs_rise) begin
            state_d   = ST_IDLE;
            addr_d    = '0;
            tx_byte_d = ID_BYTE;
            tx_load_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            cs_q        <= 1'b1;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
            tx_byte_q   <= ID_BYTE;
            tx_load_q   <= 1'b0;
            init_q      <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_cnt_q   <= 8'h00;
        end else begin
            cs_q        <= cs_s;
            state_q     <= state_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
            init_q      <= 1'b0;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) o_regs[8*i +: 8] = regs_q[i];
    end

    assign o_tx_byte   = tx_byte_q;
    assign o_tx_load   = tx_load_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected tx loads and register writes are queued
// as stimulus is driven and popped as the DUT pulses o_tx_load / o_wr_strobe.
module tb_spi_reg_ctrl;

    logic        i_clk;
    logic        i_sys_rst;
    logic        i_cs;
    logic [7:0]  i_rx_byte;
    logic        i_rx_valid;
    logic [7:0]  o_tx_byte;
    logic        o_tx_load;
    logic [63:0] o_regs;
    logic        o_wr_strobe;
    logic [2:0]  o_wr_addr;
    logic [7:0]  o_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  regs_m [8];
    logic [7:0]  tx_q [$];
    logic [10:0] wr_q [$];

    spi_reg_ctrl #(.NUM_REGS(8), .ADDR_W(3), .ID_BYTE(8'hA5)) dut (
        .i_clk       (i_clk),
        .i_sys_rst   (i_sys_rst),
        .i_cs        (i_cs),
        .i_rx_byte   (i_rx_byte),
        .i_rx_valid  (i_rx_valid),
        .o_tx_byte   (o_tx_byte),
        .o_tx_load   (o_tx_load),
        .o_regs      (o_regs),
        .o_wr_strobe (o_wr_strobe),
        .o_wr_addr   (o_wr_addr),
        .o_err_cnt   (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int n);
        return o_regs[8*n +: 8];
    endfunction

    always @(negedge i_clk) begin
        if (i_sys_rst) begin
            if (o_tx_load) begin
                chk("tx_load_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) chk("tx_byte", o_tx_byte, tx_q.pop_front());
            end
            if (o_wr_strobe) begin
                chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    logic [10:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", o_wr_addr, e[10:8]);
                    chk("wr_data", dut_reg(int'(e[10:8])), e[7:0]);
                end
            end
        end
    end

    task automatic exp_wr(input logic [2:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        regs_m[a] = d;
    endtask

    task automatic exp_rd(input logic [2:0] a);
        tx_q.push_back(regs_m[a]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (6) @(negedge i_clk);
    endtask

    task automatic cs_low();
        @(negedge i_clk);
        i_cs = 1'b0;
        repeat (6) @(negedge i_clk);
    endtask

    task automatic cs_high();
        @(negedge i_clk);
        i_cs = 1'b1;
        tx_q.push_back(8'hA5);
        repeat (8) @(negedge i_clk);
    endtask

    task automatic chk_regs(input string tag);
        for (int n = 0; n < 8; n++) chk($sformatf("%s_reg%0d", tag, n), dut_reg(n), regs_m[n]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_byte"}, o_tx_byte, 8'hA5);
        chk({tag, "_tx_load"}, o_tx_load, 1'b0);
        chk({tag, "_wr_strobe"}, o_wr_strobe, 1'b0);
        chk({tag, "_wr_addr"}, o_wr_addr, 3'd0);
        chk({tag, "_err_cnt"}, o_err_cnt, 8'd0);
        chk({tag, "_regs"}, o_regs[63:32], 32'd0);
        chk({tag, "_regs_lo"}, o_regs[31:0], 32'd0);
    endtask

    initial begin
        for (int n = 0; n < 8; n++) regs_m[n] = 8'h00;
        i_sys_rst  = 1'b0;
        i_cs       = 1'b1;
        i_rx_byte  = 8'h00;
        i_rx_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("rst");
        tx_q.push_back(8'hA5);
        i_sys_rst = 1'b1;
        repeat (4) @(negedge i_clk);

        // Burst write to reg2..reg3.
        cs_low();
        send_byte(8'h82);
        exp_wr(3'd2, 8'h11); send_byte(8'h11);
        exp_wr(3'd3, 8'h22); send_byte(8'h22);
        cs_high();
        chk_regs("wr1");

        // Preload 6,7,0 (write wraps), then burst read wrapping 7->0.
        cs_low();
        send_byte(8'h86);
        exp_wr(3'd6, 8'hAA); send_byte(8'hAA);
        exp_wr(3'd7, 8'hBB); send_byte(8'hBB);
        exp_wr(3'd0, 8'hCC); send_byte(8'hCC);
        cs_high();
        cs_low();
        exp_rd(3'd6); send_byte(8'h06);
        exp_rd(3'd7); send_byte(8'h00);
        exp_rd(3'd0); send_byte(8'h00);
        exp_rd(3'd1); send_byte(8'h00);
        cs_high();

        // Illegal command, then saturation of the error counter.
        cs_low();
        send_byte(8'h48);
        send_byte(8'h55);
        cs_high();
        chk("err_one", o_err_cnt, 8'd1);
        chk_regs("drop");
        for (int f = 0; f < 300; f++) begin
            cs_low();
            send_byte(8'h40 | 8'(f & 8'h3F) | 8'h08);
            send_byte(8'(f));
            cs_high();
            if (f == 99) chk("err_101", o_err_cnt, 8'd101);
        end
        chk("err_sat", o_err_cnt, 8'hFF);
        chk_regs("drop_many");

        // Write data arrives in the same cycle as the synchronized CS rise.
        cs_low();
        send_byte(8'h81);
        exp_wr(3'd1, 8'h77);
        @(negedge i_clk);
        i_cs = 1'b1;
        tx_q.push_back(8'hA5);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rx_byte  = 8'h77;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (8) @(negedge i_clk);
        chk("edge_reg1", dut_reg(1), 8'h77);
        cs_low();
        exp_rd(3'd1); send_byte(8'h01);
        exp_rd(3'd2); send_byte(8'h00);
        cs_high();

        // Asynchronous reset in the middle of a write burst.
        cs_low();
        send_byte(8'h80);
        exp_wr(3'd0, 8'h01); send_byte(8'h01);
        exp_wr(3'd1, 8'h02); send_byte(8'h02);
        @(negedge i_clk);
        i_sys_rst = 1'b0;
        i_cs      = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        for (int n = 0; n < 8; n++) regs_m[n] = 8'h00;
        repeat (3) @(negedge i_clk);
        tx_q.push_back(8'hA5);
        i_sys_rst = 1'b1;
        repeat (4) @(negedge i_clk);
        cs_low();
        send_byte(8'h83);
        exp_wr(3'd3, 8'h5A); send_byte(8'h5A);
        exp_wr(3'd4, 8'hC3); send_byte(8'hC3);
        cs_high();
        chk_regs("post_rst");

        // Bytes while CS is high must be ignored.
        send_byte(8'h85);
        send_byte(8'h33);
        send_byte(8'h48);
        chk_regs("idle_rx");
        chk("idle_err", o_err_cnt, 8'd0);

        repeat (4) @(negedge i_clk);
        chk("tx_q_drained", tx_q.size(), 32'd0);
        chk("wr_q_drained", wr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller on the system-clock side of the SPI slave. It takes received bytes from the slave, decodes a one-byte command per chip-select frame, and performs burst writes into a local register bank or burst reads out of it. For reads, it loads the byte to transmit back into the slave. The register bank drives the design's configuration outputs (LED pattern, blink rate and so on).

## Interface
Parameters:
- `NUM_REGS`, default 8: number of 8-bit registers; power of two, 2..16.
- `ADDR_W`, default 3: equals log2(`NUM_REGS`).
- `ID_BYTE`, default 8'hA5: byte presented for transmit whenever no read data is pending.

Ports:
- `i_clk`, in, 1: system clock.
- `i_sys_rst`, in, 1: reset, asynchronous, active-low.
- `i_cs`, in, 1: raw SPI chip select, active-low, asynchronous to `i_clk`.
- `i_rx_byte`, in, 8: received byte from the SPI slave.
- `i_rx_valid`, in, 1: one-cycle high pulse; `i_rx_byte` is valid.
- `o_tx_byte`, out, 8: next byte for the slave to shift out.
- `o_tx_load`, out, 1: one-cycle pulse; slave captures `o_tx_byte`.
- `o_regs`, out, 8*`NUM_REGS`: flattened register bank; reg n is at [8n+7:8n].
- `o_wr_strobe`, out, 1: one-cycle pulse per committed register write.
- `o_wr_addr`, out, `ADDR_W`: address of the last committed write.
- `o_err_cnt`, out, 8: count of illegal commands; saturates at 8'hFF.

## Operation
- `i_cs` passes through a 2-flop synchronizer to give `cs_s`. A rising edge of `cs_s` marks end of frame; a falling edge marks start of frame.
- Command byte layout: bit7 W (1 = write, 0 = read); bits[6:ADDR_W] must be zero; bits[ADDR_W-1:0] start address.
- States:
  - IDLE: waiting for `cs_s` to fall. On the fall, go to CMD.
  - CMD: the first `i_rx_valid` is decoded. A legal write goes to WR. A legal read goes to RD. Any nonzero reserved bit goes to DROP and increments `o_err_cnt`.
  - WR: each `i_rx_valid` writes `i_rx_byte` into reg[addr], pulses `o_wr_strobe`, updates `o_wr_addr`, then increments addr.
  - RD: each `i_rx_valid` (the dummy byte from the master) increments addr and loads reg[addr+1].
  - DROP: ignores all bytes.
- A rising edge of `cs_s` in any state goes to IDLE, sets addr to 0 and loads `ID_BYTE`.
- The address pointer wraps modulo `NUM_REGS`: `NUM_REGS`-1 is followed by 0.
- Read data is taken from the bank at load time. A write earlier in the same frame is visible to a later read only in a later frame, because a frame is either a write or a read.
- If `i_rx_valid` and the `cs_s` rise occur in the same cycle, the byte is processed first: a WR commit happens, the error count increments if applicable, and then the state is IDLE.
- `i_rx_valid` while in IDLE is ignored.

## Timing
- Reset values: `o_regs` = 0; `o_tx_byte` = `ID_BYTE`; `o_tx_load` = 0; `o_wr_strobe` = 0; `o_wr_addr` = 0; `o_err_cnt` = 0; state = IDLE; addr = 0. The first cycle after reset release pulses `o_tx_load` with `ID_BYTE`.
- Write latency: `i_rx_valid` at cycle t updates `o_regs` and pulses `o_wr_strobe` at t+1 (registered).
- Read load: a read command `i_rx_valid` at t sets `o_tx_byte` = reg[addr] and pulses `o_tx_load` at t+1.
- `i_cs` to state: 2-3 `i_clk` cycles of synchronizer delay, plus 1 cycle to register the state.
- The IDLE reload of `ID_BYTE` pulses `o_tx_load` once, one cycle after the `cs_s` rise is detected.
- `o_tx_load` pulses at most once per cycle; a read load and the IDLE reload never coincide, because a `cs_s` rise takes priority and loads `ID_BYTE`.
- System requirement: `i_clk` ≥ 4× SCK, so a load completes within one SPI byte time.

## Structure
- Shared package `spi_ctrl_pkg`:
  - State encoding (IDLE, CMD, WR, RD, DROP).
  - Command field constants: W bit index, reserved mask.
  - `ID_BYTE` default.
- Sub-module `sync_2ff`: single-bit 2-flop synchronizer with asynchronous active-low reset, reset value 1 (CS inactive). Reusable for other asynchronous inputs.
- Register bank, address counter and FSM stay in `spi_reg_ctrl`.

## Test plan
- Reset, then frame: CS low; bytes 8'h82, 8'h11, 8'h22; CS high. Expect reg2 = 8'h11, reg3 = 8'h22; two `o_wr_strobe` pulses with `o_wr_addr` 2 then 3; then `o_tx_load` with 8'hA5.
- Preload reg6 = 8'hAA, reg7 = 8'hBB, reg0 = 8'hCC. Frame: bytes 8'h06, then three dummy bytes. Expect `o_tx_load` values 8'hAA, 8'hBB, 8'hCC, showing wrap 7→0.
- Command 8'h48 (reserved bit set) followed by 8'h55. Expect no writes, `o_err_cnt` = 1, and the state returns to IDLE on CS high. With 300 illegal frames, `o_err_cnt` = 8'hFF.
- CS rises in the same cycle as `i_rx_valid` carrying write data 8'h77 to reg1. Expect reg1 = 8'h77, then IDLE; the next frame's command is decoded correctly.
- Assert `i_sys_rst` low mid-write-burst. Expect all outputs at reset values immediately (asynchronous); after release, the next frame operates normally.
- `i_rx_valid` pulses while CS is high. Expect no state change and no writes.
